// File: rtl/clock_keeper_if.sv
// Bundle of run/set controls and time-of-day outputs between the clock keeper and its users.
interface clock_keeper_if;
    logic       run;
    logic       hplus;
    logic       mplus;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       sec_tick;
    logic       hour_wrap;
    logic       day;

    modport master (
        output run, hplus, mplus,
        input  hour_bcd, min_bcd, sec_bcd, sec_tick, hour_wrap, day
    );

    modport slave (
        input  run, hplus, mplus,
        output hour_bcd, min_bcd, sec_bcd, sec_tick, hour_wrap, day
    );
endinterface

// File: rtl/clock_keeper.sv
// Time-of-day keeper: prescaled seconds, BCD hh:mm:ss counters with set pulses, and day/night flag.
module clock_keeper #(
    parameter int CLK_DIV   = 1000,
    parameter int DAY_START = 6,
    parameter int DAY_END   = 22
) (
    input  logic           clk,
    input  logic           rst,
    clock_keeper_if.slave  bus
);
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    hour_q, min_q, sec_q;
    logic [7:0]    hour_d, min_d, sec_d;
    logic          tick_q, wrap_q, day_q;
    logic          wrap_d, day_d;
    logic          min_carry, min_wrap, hour_carry;
    logic [4:0]    hour_bin;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return v + 8'd1;
    endfunction

    always_comb begin
        tick       = bus.run && (presc == PW'(CLK_DIV - 1));
        sec_d      = sec_q;
        min_carry  = 1'b0;
        min_d      = min_q;
        min_wrap   = 1'b0;
        hour_d     = hour_q;
        wrap_d     = 1'b0;

        if (tick) begin
            min_carry = (sec_q == 8'h59);
            sec_d     = bcd_inc(sec_q, 8'h59);
        end

        // Carry is applied before the set pulse, so a wrap during a carry cycle counts as natural.
        if (min_carry) begin
            min_wrap = (min_q == 8'h59);
            min_d    = bcd_inc(min_q, 8'h59);
        end
        if (bus.mplus) begin
            min_wrap = min_wrap || (min_d == 8'h59);
            min_d    = bcd_inc(min_d, 8'h59);
        end
        hour_carry = min_carry && min_wrap;

        if (hour_carry) begin
            wrap_d = (hour_q == 8'h23);
            hour_d = bcd_inc(hour_q, 8'h23);
        end
        if (bus.hplus)
            hour_d = bcd_inc(hour_d, 8'h23);

        hour_bin = 5'(hour_d[7:4]) * 5'd10 + 5'(hour_d[3:0]);
        day_d    = (int'(hour_bin) >= DAY_START) && (int'(hour_bin) < DAY_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            sec_q  <= 8'h00;
            min_q  <= 8'h00;
            hour_q <= 8'h00;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            day_q  <= 1'b0;
        end else begin
            if (bus.run)
                presc <= tick ? '0 : presc + PW'(1);
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            tick_q <= tick;
            wrap_q <= wrap_d;
            day_q  <= day_d;
        end
    end

    assign bus.hour_bcd  = hour_q;
    assign bus.min_bcd   = min_q;
    assign bus.sec_bcd   = sec_q;
    assign bus.sec_tick  = tick_q;
    assign bus.hour_wrap = wrap_q;
    assign bus.day       = day_q;
endmodule
